// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the single combinational bitmap ROM between the pixel pipeline (always wins,
// zero latency) and a queued background requester serviced whenever the pixel side is idle.
module rom_fetch_arbiter #(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned TAG_W         = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STARVE_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_req,
  input  logic [ADDR_W-1:0]             pix_addr,
  output logic [DATA_W-1:0]             pix_data,
  input  logic                          bg_valid,
  output logic                          bg_ready,
  input  logic [ADDR_W-1:0]             bg_addr,
  input  logic [TAG_W-1:0]              bg_tag,
  output logic                          bg_rvalid,
  output logic [DATA_W-1:0]             bg_rdata,
  output logic [TAG_W-1:0]              bg_rtag,
  output logic                          bg_starved,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(STARVE_CYCLES + 1);

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [TAG_W-1:0]  q_tag  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  wait_cnt;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Ready and service decisions use only the registered level, so there is no bypass path.
  assign empty      = (level == '0);
  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign bg_ready   = ~full & ~reset;
  assign push       = bg_valid & bg_ready;
  assign pop        = ~pix_req & ~empty;
  assign rom_addr   = pop ? q_addr[rd_ptr] : pix_addr;
  assign pix_data   = rom_data;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bg_addr;
      q_tag[wr_ptr]  <= bg_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      bg_rvalid <= 1'b0;
      bg_rdata  <= '0;
      bg_rtag   <= '0;
    end else begin
      bg_rvalid <= pop;
      if (pop) begin
        bg_rdata <= rom_data;
        bg_rtag  <= q_tag[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Starved is raised on the same edge the saturating wait count reaches its limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      bg_starved <= 1'b0;
    end else if (pop) begin
      wait_cnt <= '0;
    end else if (!empty) begin
      if (wait_cnt != CNT_W'(STARVE_CYCLES)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= CNT_W'(STARVE_CYCLES - 1)) begin
        bg_starved <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based behavioural model.
module tb_rom_fetch_arbiter;

  localparam int DEPTH  = 4;
  localparam int STARVE = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_req = 1'b0;
  logic [11:0] pix_addr = '0;
  logic [7:0]  pix_data;
  logic        bg_valid = 1'b0;
  logic        bg_ready;
  logic [11:0] bg_addr = '0;
  logic [1:0]  bg_tag = '0;
  logic        bg_rvalid;
  logic [7:0]  bg_rdata;
  logic [1:0]  bg_rtag;
  logic        bg_starved;
  logic [2:0]  fifo_level;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;

  always #5 clk = ~clk;

  assign rom_data = rom_addr[7:0] ^ 8'hA5;

  rom_fetch_arbiter #(
    .ADDR_W(12), .DATA_W(8), .TAG_W(2), .FIFO_DEPTH(DEPTH), .STARVE_CYCLES(STARVE)
  ) dut (
    .clk(clk), .reset(reset), .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data),
    .bg_valid(bg_valid), .bg_ready(bg_ready), .bg_addr(bg_addr), .bg_tag(bg_tag),
    .bg_rvalid(bg_rvalid), .bg_rdata(bg_rdata), .bg_rtag(bg_rtag), .bg_starved(bg_starved),
    .fifo_level(fifo_level), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  typedef struct packed { logic [11:0] addr; logic [1:0] tag; } ent_t;

  ent_t        mq[$];
  logic        m_rvalid  = 1'b0;
  logic [7:0]  m_rdata   = '0;
  logic [1:0]  m_rtag    = '0;
  logic        m_starved = 1'b0;
  int          m_wait    = 0;
  logic [1:0]  seen[$];
  int          errors = 0;
  int          checks = 0;

  logic [35:0] dut_vec;
  assign dut_vec = {rom_addr, pix_data, bg_ready, bg_rvalid, bg_rdata, bg_rtag, bg_starved, fifo_level};

  function automatic logic [11:0] m_rom_addr();
    return (!pix_req && mq.size() != 0) ? mq[0].addr : pix_addr;
  endfunction

  function automatic logic [35:0] m_vec();
    logic [11:0] a;
    logic [7:0]  d;
    logic        rdy;
    a   = m_rom_addr();
    d   = a[7:0] ^ 8'hA5;
    rdy = !reset && (mq.size() < DEPTH);
    return {a, d, rdy, m_rvalid, m_rdata, m_rtag, m_starved, 3'(mq.size())};
  endfunction

  // Advances one clock: the model applies the rules to the inputs seen at the edge.
  task automatic tick();
    ent_t h;
    logic svc;
    logic acc;
    @(posedge clk);
    svc = !pix_req && (mq.size() != 0);
    acc = bg_valid && (mq.size() < DEPTH) && !reset;
    if (reset) begin
      mq.delete();
      m_rvalid = 1'b0; m_rdata = '0; m_rtag = '0; m_starved = 1'b0; m_wait = 0;
    end else begin
      m_rvalid = svc;
      if (svc) begin
        h = mq.pop_front();
        m_rdata = h.addr[7:0] ^ 8'hA5;
        m_rtag  = h.tag;
        m_wait  = 0;
      end else if (mq.size() != 0 && m_wait < STARVE) begin
        m_wait++;
      end
      if (m_wait >= STARVE) m_starved = 1'b1;
      if (acc) mq.push_back(ent_t'({bg_addr, bg_tag}));
    end
    #1;
    if (bg_rvalid) seen.push_back(bg_rtag);
  endtask

  task automatic drive(input logic pr, input logic [11:0] pa, input logic v,
                       input logic [11:0] a, input logic [1:0] t);
    pix_req = pr; pix_addr = pa; bg_valid = v; bg_addr = a; bg_tag = t;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 12'h000, 1, 12'h000, 0);
    tick(); tick();
    checks++;
    if (dut_vec !== m_vec()) begin
      errors++; $display("FAIL reset_vec: got %h expected %h", dut_vec, m_vec());
    end
    checks++;
    if ({bg_ready, bg_rvalid, bg_rdata, bg_rtag, bg_starved, fifo_level} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {bg_ready, bg_rvalid, bg_rdata, bg_rtag, bg_starved, fifo_level});
    end
    reset = 1'b0;
    drive(0, 12'h000, 0, 12'h000, 0);
    checks++;
    if (bg_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", bg_ready);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 12'h055, (i == 0), 12'h123, 2'd1);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL idle_c%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      checks++;
      if (bg_rvalid !== (i == 2)) begin
        errors++; $display("FAIL idle_rvalid_c%0d: got %b expected %b", i, bg_rvalid, (i == 2));
      end
      if (i == 2) begin
        checks++;
        if ({bg_rdata, bg_rtag} !== {8'h86, 2'd1}) begin
          errors++; $display("FAIL idle_resp: got %h/%0d expected 86/1", bg_rdata, bg_rtag);
        end
      end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [7:0] got;
    for (int i = 0; i < 5; i++) begin
      drive(1, 12'h040, 1, 12'(12'h200 + i), 2'(i));
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL prio_push%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      tick();
    end
    drive(1, 12'h040, 0, 12'h000, 0);
    checks++;
    if ({rom_addr, pix_data, bg_ready, bg_rvalid, fifo_level} !== {12'h040, 8'hE5, 1'b0, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL prio_full: got %h expected 040e5004 (addr,data,ready,rvalid,level)",
               {rom_addr, pix_data, 3'b0, bg_ready, 3'b0, bg_rvalid, 1'b0, fifo_level});
    end
    tick();
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      drive(0, 12'h040, 0, 12'h000, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL prio_drain%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      tick();
    end
    checks++;
    got = (seen.size() == 4) ? {seen[0], seen[1], seen[2], seen[3]} : 8'hxx;
    if (seen.size() != 4 || got !== 8'b00_01_10_11) begin
      errors++; $display("FAIL prio_order: got %0d responses tags %b expected 4 tags 00011011", seen.size(), got);
    end
  endtask

  task automatic test_starve();
    reset = 1'b1; drive(1, 12'h000, 0, 12'h000, 0); tick(); reset = 1'b0;
    drive(1, 12'h010, 1, 12'h3C3, 2'd2);
    tick();
    for (int j = 1; j <= 20; j++) begin
      drive(1, 12'($urandom_range(0, 4095)), 0, 12'h000, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL starve_w%0d: got %h expected %h", j, dut_vec, m_vec());
      end
      tick();
      if (j == 15 || j == 16) begin
        checks++;
        if (bg_starved !== (j == 16)) begin
          errors++; $display("FAIL starve_edge_w%0d: got %b expected %b", j, bg_starved, (j == 16));
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      drive(0, 12'h010, 0, 12'h000, 0);
      tick();
    end
    checks++;
    if ({bg_starved, fifo_level} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL starve_sticky: got starved=%b level=%0d expected 1/0", bg_starved, fifo_level);
    end
  endtask

  task automatic test_interleave();
    logic [5:0] got;
    reset = 1'b1; drive(1, 12'h000, 0, 12'h000, 0); tick(); reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 12'h700, 1, 12'($urandom_range(0, 4095)), 2'(i));
      tick();
    end
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      drive((i % 2) == 0, 12'($urandom_range(0, 4095)), 0, 12'h000, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL inter_c%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      tick();
    end
    checks++;
    got = (seen.size() == 3) ? {seen[0], seen[1], seen[2]} : 6'hxx;
    if (seen.size() != 3 || got !== 6'b01_10_11) begin
      errors++; $display("FAIL inter_order: got %0d responses tags %b expected 3 tags 011011", seen.size(), got);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 19; i++) begin
      drive(1, 12'h2A0, (i < 3), 12'(12'h100 + i), 2'(i));
      tick();
    end
    checks++;
    if ({bg_starved, fifo_level} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL rmid_pre: got starved=%b level=%0d expected 1/3", bg_starved, fifo_level);
    end
    reset = 1'b1;
    drive(1, 12'h2A0, 1, 12'h0FF, 0);
    checks++;
    if (bg_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_ready_in_reset: got %b expected 0", bg_ready);
    end
    tick();
    reset = 1'b0;
    seen.delete();
    drive(0, 12'h2A0, 0, 12'h000, 0);
    checks++;
    if ({fifo_level, bg_ready, bg_starved, bg_rvalid} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_post: got level=%0d ready=%b starved=%b rvalid=%b expected 0/1/0/0",
               fifo_level, bg_ready, bg_starved, bg_rvalid);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 12'h2A0, 0, 12'h000, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL rmid_c%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      tick();
    end
    checks++;
    if (seen.size() != 0) begin
      errors++; $display("FAIL rmid_no_resp: got %0d responses expected 0", seen.size());
    end
  endtask

  task automatic test_push_pop();
    logic [5:0] got;
    reset = 1'b1; drive(1, 12'h000, 0, 12'h000, 0); tick(); reset = 1'b0;
    drive(1, 12'h000, 1, 12'h111, 2'd0); tick();
    drive(1, 12'h000, 1, 12'h222, 2'd1); tick();
    seen.delete();
    drive(0, 12'h000, 1, 12'h333, 2'd2);
    checks++;
    if (rom_addr !== 12'h111) begin
      errors++; $display("FAIL pp_head_addr: got %h expected 111", rom_addr);
    end
    tick();
    checks++;
    if ({fifo_level, bg_rvalid, bg_rdata, bg_rtag} !== {3'd2, 1'b1, 8'hB4, 2'd0}) begin
      errors++;
      $display("FAIL pp_same_cycle: got level=%0d rvalid=%b data=%h tag=%0d expected 2/1/b4/0",
               fifo_level, bg_rvalid, bg_rdata, bg_rtag);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 12'h000, 0, 12'h000, 0);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL pp_drain%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      tick();
    end
    checks++;
    got = (seen.size() == 3) ? {seen[0], seen[1], seen[2]} : 6'hxx;
    if (seen.size() != 3 || got !== 6'b00_01_10) begin
      errors++; $display("FAIL pp_order: got %0d responses tags %b expected 3 tags 000110", seen.size(), got);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) != 0, 12'($urandom_range(0, 4095)), $urandom_range(0, 1) == 1,
            12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)));
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++; $display("FAIL rand_c%0d: got %h expected %h", i, dut_vec, m_vec());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_priority();
    test_starve();
    test_interleave();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
